// File: rtl/ballot_input_conditioner_if.sv
// Ballot conditioner bus: raw buttons, voter ID and tally-stage status in,
// conditioned vote pulses and status out. master = tally/ID side driving
// the inputs, slave = the conditioner.
interface ballot_input_conditioner_if #(
  parameter int ID_WIDTH = 4
);
  logic                btn_a;
  logic                btn_b;
  logic                btn_c;
  logic [ID_WIDTH-1:0] voter_id_in;
  logic                voting_enabled;
  logic                busy;
  logic                vote_a;
  logic                vote_b;
  logic                vote_c;
  logic [ID_WIDTH-1:0] voter_id_out;
  logic                multi_press_err;
  logic                rejected;
  logic                ready;

  modport master (
    output btn_a, btn_b, btn_c, voter_id_in, voting_enabled, busy,
    input  vote_a, vote_b, vote_c, voter_id_out, multi_press_err, rejected, ready
  );

  modport slave (
    input  btn_a, btn_b, btn_c, voter_id_in, voting_enabled, busy,
    output vote_a, vote_b, vote_c, voter_id_out, multi_press_err, rejected, ready
  );
endinterface

// File: rtl/ballot_input_conditioner.sv
// Ballot input conditioner: synchronizes and debounces three candidate
// buttons, then turns a single clean press into one registered vote pulse
// paired with a latched voter ID. Multi-button presses are flagged, ballots
// are held while the tally stage is busy, and dropped when voting is off.

// One button lane: 2-flop synchronizer followed by a saturating debouncer.
module bic_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], raw};
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing edges;
  // any agreeing edge restarts the count, so short bounce is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module ballot_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ID_WIDTH        = 4
) (
  input logic                        clk,
  input logic                        reset_n,
  ballot_input_conditioner_if.slave  bus
);
  localparam int NUM_LANES = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  // Lane order everywhere: [0]=a, [1]=b, [2]=c.
  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] lvl;
  logic [NUM_LANES-1:0] cand;
  logic [NUM_LANES-1:0] vote_q;
  logic [1:0]           state;
  logic                 err_q;
  logic                 rej_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 any_hi;
  logic                 one_hi;

  assign raw = {bus.btn_c, bus.btn_b, bus.btn_a};

  bic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_LANES-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw),
    .level   (lvl)
  );

  assign any_hi = |lvl;
  assign one_hi = any_hi && ((lvl & (lvl - 1'b1)) == '0);

  // Ballot FSM; all pulse outputs are registered and default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cand   <= '0;
      vote_q <= '0;
      err_q  <= 1'b0;
      rej_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      vote_q <= '0;
      err_q  <= 1'b0;
      rej_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (one_hi) begin
            id_q <= bus.voter_id_in;
            cand <= lvl;
            if (!bus.voting_enabled) begin
              rej_q <= 1'b1;
              state <= S_WAIT;
            end else if (!bus.busy) begin
              vote_q <= lvl;
              state  <= S_WAIT;
            end else begin
              state <= S_PENDING;
            end
          end else if (any_hi) begin
            err_q <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_PENDING: begin
          // Candidate was frozen at accept; button activity here is ignored.
          if (!bus.voting_enabled) begin
            rej_q <= 1'b1;
            state <= S_WAIT;
          end else if (!bus.busy) begin
            vote_q <= cand;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!any_hi) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.vote_a          = vote_q[0];
  assign bus.vote_b          = vote_q[1];
  assign bus.vote_c          = vote_q[2];
  assign bus.voter_id_out    = id_q;
  assign bus.multi_press_err = err_q;
  assign bus.rejected        = rej_q;
  // Reflects the state register directly, so it is high right out of reset.
  assign bus.ready           = (state == S_IDLE);

  // A candidate recorded for PENDING is always exactly one lane.
  a_onehot_vote : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(vote_q));
  a_pend_cand   : assert property (@(posedge clk) disable iff (!reset_n)
                                   (state == S_PENDING) |-> $onehot(cand));
endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Directed bench for ballot_input_conditioner with DEBOUNCE_CYCLES=4:
// table of single-press scenarios plus hand-written busy/disable/reset
// sequences. Outputs are sampled 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_ballot_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n;

  ballot_input_conditioner_if #(.ID_WIDTH(4)) bus ();

  ballot_input_conditioner #(.DEBOUNCE_CYCLES(D), .ID_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btns;   // {c,b,a}
    logic [3:0] id;
    logic       en;
    int         hold;
    int         na, nb, nc, nerr, nrej;
    logic [3:0] exp_id;
  } vec_t;

  vec_t vecs [9];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int na, nb, nc, nerr, nrej, n_hot, first_evt, last_nr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    na = 0; nb = 0; nc = 0; nerr = 0; nrej = 0; n_hot = 0;
    first_evt = -1; last_nr = -1;
  endtask

  // Advance one cycle and sample outputs away from the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.vote_a) na++;
    if (bus.vote_b) nb++;
    if (bus.vote_c) nc++;
    if (bus.multi_press_err) nerr++;
    if (bus.rejected) nrej++;
    if ((bus.vote_a || bus.vote_b || bus.vote_c || bus.multi_press_err || bus.rejected)
        && first_evt < 0) first_evt = cyc;
    if (int'(bus.vote_a) + int'(bus.vote_b) + int'(bus.vote_c) > 1) n_hot++;
    if (!bus.ready) last_nr = cyc;
  endtask

  task automatic set_btns(input logic [2:0] b);
    bus.btn_a = b[0];
    bus.btn_b = b[1];
    bus.btn_c = b[2];
  endtask

  initial begin
    int pc, rc, hot_total;
    bit ev;
    //             btns    id    en hold na nb nc err rej exp_id
    vecs[0] = '{3'b001, 4'h1, 1, 12, 1, 0, 0, 0, 0, 4'h1};  // clean press a
    vecs[1] = '{3'b010, 4'h2, 1,  8, 0, 1, 0, 0, 0, 4'h2};
    vecs[2] = '{3'b100, 4'hF, 1,  8, 0, 0, 1, 0, 0, 4'hF};
    vecs[3] = '{3'b101, 4'h5, 1,  8, 0, 0, 0, 1, 0, 4'hF};  // a+c same edge
    vecs[4] = '{3'b001, 4'h3, 0,  8, 0, 0, 0, 0, 1, 4'h3};  // disabled
    vecs[5] = '{3'b111, 4'h7, 1,  8, 0, 0, 0, 1, 0, 4'h3};
    vecs[6] = '{3'b010, 4'hA, 1,  5, 0, 1, 0, 0, 0, 4'hA};  // short but enough
    vecs[7] = '{3'b100, 4'h4, 1,  3, 0, 0, 0, 0, 0, 4'hA};  // shorter than D
    vecs[8] = '{3'b011, 4'h6, 1,  8, 0, 0, 0, 1, 0, 4'hA};

    hot_total = 0;
    reset_n = 1'b0;
    set_btns(3'b000);
    bus.voter_id_in = 4'h0;
    bus.voting_enabled = 1'b1;
    bus.busy = 1'b0;
    clr();
    repeat (3) tick();
    check("rst_votes", int'({bus.vote_c, bus.vote_b, bus.vote_a}), 0);
    check("rst_err_rej", int'({bus.multi_press_err, bus.rejected}), 0);
    check("rst_id", int'(bus.voter_id_out), 0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", int'(bus.ready), 1);

    // Table-driven single-press scenarios.
    for (int i = 0; i < 9; i++) begin
      clr();
      set_btns(vecs[i].btns);
      bus.voter_id_in = vecs[i].id;
      bus.voting_enabled = vecs[i].en;
      pc = cyc;
      repeat (vecs[i].hold) tick();
      set_btns(3'b000);
      rc = cyc;
      repeat (20) tick();
      ev = (vecs[i].na + vecs[i].nb + vecs[i].nc + vecs[i].nerr + vecs[i].nrej) > 0;
      check($sformatf("v%0d_vote_a", i), na, vecs[i].na);
      check($sformatf("v%0d_vote_b", i), nb, vecs[i].nb);
      check($sformatf("v%0d_vote_c", i), nc, vecs[i].nc);
      check($sformatf("v%0d_err", i), nerr, vecs[i].nerr);
      check($sformatf("v%0d_rej", i), nrej, vecs[i].nrej);
      check($sformatf("v%0d_id", i), int'(bus.voter_id_out), int'(vecs[i].exp_id));
      check($sformatf("v%0d_first_evt", i), first_evt, ev ? pc + D + 3 : -1);
      check($sformatf("v%0d_last_not_ready", i), last_nr, ev ? rc + D + 2 : -1);
      hot_total += n_hot;
    end
    bus.voting_enabled = 1'b1;

    // Bounce on b followed by a clean hold.
    clr();
    bus.voter_id_in = 4'hB;
    set_btns(3'b010); tick();
    set_btns(3'b000); tick();
    set_btns(3'b010); tick();
    set_btns(3'b000); tick();
    set_btns(3'b010);
    pc = cyc;
    repeat (8) tick();
    set_btns(3'b000);
    repeat (16) tick();
    check("bounce_vote_b", nb, 1);
    check("bounce_other_votes", na + nc, 0);
    check("bounce_err", nerr, 0);
    check("bounce_first_evt", first_evt, pc + D + 3);
    hot_total += n_hot;

    // Busy hold: c pressed while busy, released from busy later.
    clr();
    bus.busy = 1'b1;
    bus.voter_id_in = 4'hC;
    set_btns(3'b100);
    pc = cyc;
    repeat (11) tick();
    check("busy_ready_low", int'(bus.ready), 0);
    check("busy_no_vote", nc, 0);
    bus.busy = 1'b0;
    tick();
    check("busy_vote_c_now", nc, 1);
    check("busy_first_evt", first_evt, pc + 12);
    repeat (2) tick();
    set_btns(3'b000);
    repeat (16) tick();
    check("busy_vote_c_total", nc, 1);
    check("busy_id", int'(bus.voter_id_out), 12);
    hot_total += n_hot;

    // Enable drops while the ballot is pending.
    clr();
    bus.busy = 1'b1;
    bus.voter_id_in = 4'hD;
    set_btns(3'b001);
    pc = cyc;
    repeat (10) tick();
    bus.voting_enabled = 1'b0;
    tick();
    check("pend_dis_rej", nrej, 1);
    check("pend_dis_first_evt", first_evt, pc + 11);
    set_btns(3'b000);
    repeat (16) tick();
    bus.busy = 1'b0;
    bus.voting_enabled = 1'b1;
    repeat (2) tick();
    check("pend_dis_votes", na + nb + nc, 0);
    check("pend_dis_rej_total", nrej, 1);
    check("pend_dis_ready", int'(bus.ready), 1);

    // Reset while a ballot is pending.
    clr();
    bus.busy = 1'b1;
    bus.voter_id_in = 4'h9;
    set_btns(3'b010);
    repeat (10) tick();
    check("rstp_id_latched", int'(bus.voter_id_out), 9);
    check("rstp_ready_low", int'(bus.ready), 0);
    reset_n = 1'b0;
    set_btns(3'b000);
    #1;
    check("rstp_imm_outs", int'({bus.vote_c, bus.vote_b, bus.vote_a,
                                  bus.multi_press_err, bus.rejected}), 0);
    check("rstp_imm_id", int'(bus.voter_id_out), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    bus.busy = 1'b0;
    repeat (20) tick();
    check("rstp_no_vote", na + nb + nc, 0);
    check("rstp_id_zero", int'(bus.voter_id_out), 0);
    check("rstp_ready", int'(bus.ready), 1);
    hot_total += n_hot;

    check("onehot_votes", hot_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
